// File: rtl/dft_output_capture.sv
// dft_output_capture
// Downstream stage of the DFT core: captures each output frame (next_out pulse
// followed by FRAME_BEATS beats of Y0..Y3) into a two-bank ping-pong buffer and
// replays frames, in capture order, over a valid/ready stream to the host.
// Dropped frames (no free bank) and aborted frames (next_out mid-capture) are
// reported through a sticky overflow flag and a saturating drop counter.
// Optional feature: define DFT_CAPTURE_CHECKSUM_EN to keep a per-bank running
// XOR of captured beats and present the head frame's value on frame_csum.
module dft_output_capture #(
    parameter int FRAME_BEATS = 16,
    parameter int DROP_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  next_out,
    input  logic [15:0]           Y0,
    input  logic [15:0]           Y1,
    input  logic [15:0]           Y2,
    input  logic [15:0]           Y3,
    input  logic                  capture_en,
    output logic [63:0]           rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic [1:0]            frames_avail,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count,
    input  logic                  clear_status,
    output logic [63:0]           frame_csum
);

    localparam int            AW        = $clog2(FRAME_BEATS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_BEATS - 1);

    localparam logic W_IDLE    = 1'b0;
    localparam logic W_CAPTURE = 1'b1;
    localparam logic R_IDLE    = 1'b0;
    localparam logic R_STREAM  = 1'b1;

    logic          w_state;
    logic [AW-1:0] wr_addr;
    logic          wr_bank;

    logic          r_state;
    logic [AW-1:0] rd_addr;
    logic          rd_bank;

    logic [1:0]    bank_full;
    logic [63:0]   mem [0:2*FRAME_BEATS-1];
    logic [63:0]   beat;

    logic start_req;
    logic frame_start;
    logic frame_drop;
    logic frame_abort;
    logic beat_write;
    logic fill_done;
    logic free_done;

    assign beat = {Y3, Y2, Y1, Y0};

    // Event decode. Banks alternate strictly, so the write pointer always
    // names the oldest bank; if that one is still full, both are occupied.
    // A bank freed by the last read this cycle still reads as full here.
    always_comb begin
        start_req   = next_out & capture_en;
        frame_start = (w_state == W_IDLE) & start_req & ~bank_full[wr_bank];
        frame_drop  = (w_state == W_IDLE) & start_req & bank_full[wr_bank];
        frame_abort = (w_state == W_CAPTURE) & start_req;
        beat_write  = (w_state == W_CAPTURE) & ~start_req;
        fill_done   = beat_write & (wr_addr == LAST_ADDR);
        free_done   = (r_state == R_STREAM) & rd_ready & (rd_addr == LAST_ADDR);
    end

    // Write FSM: wait for an accepted frame start, then store one beat per
    // cycle; a new start mid-frame restarts the same bank from address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            wr_addr <= '0;
            wr_bank <= 1'b0;
        end else if (w_state == W_IDLE) begin
            if (frame_start) begin
                w_state <= W_CAPTURE;
                wr_addr <= '0;
            end
        end else begin
            if (frame_abort) begin
                wr_addr <= '0;
            end else if (fill_done) begin
                w_state <= W_IDLE;
                wr_addr <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_addr <= wr_addr + AW'(1);
            end
        end
    end

    // Frame storage; both banks share one array addressed by {bank, beat}.
    always_ff @(posedge clk) begin
        if (beat_write) begin
            mem[{wr_bank, wr_addr}] <= beat;
        end
    end

    // Read FSM: pick up the head bank once it is full and stream its beats,
    // advancing only on an accepted transfer so data holds during stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            rd_addr <= '0;
            rd_bank <= 1'b0;
        end else if (r_state == R_IDLE) begin
            if (bank_full[rd_bank]) begin
                r_state <= R_STREAM;
                rd_addr <= '0;
            end
        end else if (rd_ready) begin
            if (rd_addr == LAST_ADDR) begin
                r_state <= R_IDLE;
                rd_addr <= '0;
                rd_bank <= ~rd_bank;
            end else begin
                rd_addr <= rd_addr + AW'(1);
            end
        end
    end

    // Bank occupancy and frame count; a fill and a free in the same cycle
    // always touch different banks and leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full    <= 2'b00;
            frames_avail <= 2'd0;
        end else begin
            if (fill_done) begin
                bank_full[wr_bank] <= 1'b1;
            end
            if (free_done) begin
                bank_full[rd_bank] <= 1'b0;
            end
            if (fill_done && !free_done) begin
                frames_avail <= frames_avail + 2'd1;
            end else if (free_done && !fill_done) begin
                frames_avail <= frames_avail - 2'd1;
            end
        end
    end

    // Status: sticky overflow on drops, saturating count of drops and aborts;
    // a clear request overrides any event in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_status) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (frame_drop) begin
                overflow <= 1'b1;
            end
            if ((frame_drop || frame_abort) && (drop_count != {DROP_CNT_W{1'b1}})) begin
                drop_count <= drop_count + DROP_CNT_W'(1);
            end
        end
    end

    assign rd_valid = (r_state == R_STREAM);
    assign rd_data  = rd_valid ? mem[{rd_bank, rd_addr}] : 64'd0;
    assign rd_last  = rd_valid & (rd_addr == LAST_ADDR);

`ifdef DFT_CAPTURE_CHECKSUM_EN
    logic [1:0][63:0] bank_csum;

    // Running XOR per bank, restarted whenever a frame (re)starts in that bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_csum <= '0;
        end else if (frame_start || frame_abort) begin
            bank_csum[wr_bank] <= 64'd0;
        end else if (beat_write) begin
            bank_csum[wr_bank] <= bank_csum[wr_bank] ^ beat;
        end
    end

    assign frame_csum = rd_valid ? bank_csum[rd_bank] : 64'd0;
`else
    assign frame_csum = 64'd0;
`endif

endmodule

// File: tb/tb_dft_output_capture.sv
// tb_dft_output_capture
// Drives frames into dft_output_capture and compares every output against a
// frame-level reference model: a queue of completed frames, a count of frames
// held, and the drop/abort bookkeeping expressed directly as frame rules.
// Honours DFT_CAPTURE_CHECKSUM_EN the same way as the design.
`timescale 1ns/1ps
module tb_dft_output_capture;

    localparam int FB = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          next_out;
    logic [15:0]   y0, y1, y2, y3;
    logic          capture_en;
    logic [63:0]   rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_last;
    logic [1:0]    frames_avail;
    logic          overflow;
    logic [DW-1:0] drop_count;
    logic          clear_status;
    logic [63:0]   frame_csum;

    always #5 clk = ~clk;

    dft_output_capture #(.FRAME_BEATS(FB), .DROP_CNT_W(DW)) dut (
        .clk(clk), .rst(rst), .next_out(next_out),
        .Y0(y0), .Y1(y1), .Y2(y2), .Y3(y3),
        .capture_en(capture_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .frames_avail(frames_avail), .overflow(overflow), .drop_count(drop_count),
        .clear_status(clear_status), .frame_csum(frame_csum)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // reference model state
    logic [63:0] exp_q[$];
    logic [63:0] csum_q[$];
    logic [63:0] cur_frame[$];
    int          m_avail;
    int          m_rd_idx;
    bit          m_in_frame;
    bit          m_ovf;
    int          m_drop;
    int          wait_cnt;
    bit          prev_stall;
    logic [63:0] prev_data;
    logic [63:0] xfer_log[$];
    bit          last_log[$];
    int          pushed;
    int          peak_avail;
    int          ready_mode;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks_total++;
        if (observed === expected) checks_passed++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    function automatic logic [63:0] beatVal(input int kind, input int f, input int k);
        case (kind)
            0:       return {16'(4*k+3), 16'(4*k+2), 16'(4*k+1), 16'(4*k)};
            1:       return {16'(f), 16'(k), 16'hC0DE, 16'(f*16+k)};
            2:       return {$urandom, $urandom};
            default: return (k == 0) ? 64'd0 : 64'h1111_2222_3333_4444;
        endcase
    endfunction

    task automatic modelReset();
        exp_q.delete(); csum_q.delete(); cur_frame.delete();
        m_avail = 0; m_rd_idx = 0; m_in_frame = 0; m_ovf = 0; m_drop = 0;
        wait_cnt = 0; prev_stall = 0; prev_data = '0;
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
    task automatic applyStimulus(input logic nx, input logic [63:0] beat, input logic clr);
        bit          fill, free, dropped, aborted;
        logic [63:0] x;
        next_out = nx;
        {y3, y2, y1, y0} = beat;
        clear_status = clr;
        rd_ready = (ready_mode == 2) ? ($urandom_range(0, 1) == 1) : (ready_mode == 1);
        @(negedge clk);
        fill = 0; free = 0; dropped = 0; aborted = 0;
        checkOutput("frames_avail", 64'(frames_avail), 64'(m_avail));
        checkOutput("overflow", 64'(overflow), 64'(m_ovf));
        checkOutput("drop_count", 64'(drop_count), 64'(m_drop));
        if (int'(frames_avail) > peak_avail) peak_avail = int'(frames_avail);
        if (rd_valid) begin
            wait_cnt = 0;
            if (prev_stall) checkOutput("rd_data_stable", rd_data, prev_data);
            if (exp_q.size() > 0) begin
                checkOutput("rd_data", rd_data, exp_q[0]);
                checkOutput("rd_last", 64'(rd_last), 64'(m_rd_idx == FB-1));
`ifdef DFT_CAPTURE_CHECKSUM_EN
                checkOutput("frame_csum", frame_csum, csum_q[0]);
`else
                checkOutput("frame_csum", frame_csum, 64'd0);
`endif
                if (rd_ready) begin
                    xfer_log.push_back(rd_data);
                    last_log.push_back(rd_last);
                    void'(exp_q.pop_front());
                    if (m_rd_idx == FB-1) begin
                        m_rd_idx = 0;
                        void'(csum_q.pop_front());
                        free = 1;
                    end else begin
                        m_rd_idx++;
                    end
                end
            end else begin
                checkOutput("rd_valid_spurious", 64'(rd_valid), 64'd0);
            end
        end else begin
            checkOutput("frame_csum_idle", frame_csum, 64'd0);
            if (m_avail > 0) begin
                wait_cnt++;
                checkOutput("rd_valid_latency", 64'(wait_cnt > 1), 64'd0);
            end
        end
        prev_stall = rd_valid && !rd_ready;
        prev_data  = rd_data;

        if (nx && capture_en) begin
            if (m_in_frame) begin
                cur_frame.delete();
                aborted = 1;
            end else if (m_avail < 2) begin
                m_in_frame = 1;
                cur_frame.delete();
            end else begin
                dropped = 1;
            end
        end else if (m_in_frame) begin
            cur_frame.push_back(beat);
            if (cur_frame.size() == FB) begin
                x = '0;
                foreach (cur_frame[i]) begin
                    exp_q.push_back(cur_frame[i]);
                    x ^= cur_frame[i];
                end
                csum_q.push_back(x);
                fill = 1;
                m_in_frame = 0;
                pushed++;
            end
        end
        if (clr) begin
            m_drop = 0;
            m_ovf  = 0;
        end else begin
            if (dropped) m_ovf = 1;
            if ((dropped || aborted) && m_drop < (1 << DW) - 1) m_drop++;
        end
        m_avail = m_avail + int'(fill) - int'(free);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        next_out = 0; clear_status = 0; {y3, y2, y1, y0} = '0;
        rst = 1;
        #2;
        checkOutput("reset_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("reset_rd_last", 64'(rd_last), 64'd0);
        checkOutput("reset_rd_data", rd_data, 64'd0);
        checkOutput("reset_frames_avail", 64'(frames_avail), 64'd0);
        checkOutput("reset_overflow", 64'(overflow), 64'd0);
        checkOutput("reset_drop_count", 64'(drop_count), 64'd0);
        checkOutput("reset_frame_csum", frame_csum, 64'd0);
        @(posedge clk);
        #1;
        rst = 0;
        modelReset();
    endtask

    task automatic sendFrame(input int kind, input int f, input int gap);
        applyStimulus(1'b1, 64'd0, 1'b0);
        for (int k = 0; k < FB; k++) applyStimulus(1'b0, beatVal(kind, f, k), 1'b0);
        for (int g = 0; g < gap; g++) applyStimulus(1'b0, 64'd0, 1'b0);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((m_avail > 0 || m_in_frame) && n < bound) begin
            applyStimulus(1'b0, 64'd0, 1'b0);
            n++;
        end
        checkOutput("drain_timeout", 64'(n >= bound), 64'd0);
        applyStimulus(1'b0, 64'd0, 1'b0);
        applyStimulus(1'b0, 64'd0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        next_out = 0; capture_en = 1; rd_ready = 0; clear_status = 0;
        {y3, y2, y1, y0} = '0;
        ready_mode = 1; pushed = 0; peak_avail = 0;
        modelReset();
        #1;
        doReset();

        // counting frame streamed with the reader always ready
        $display("[TB] counting frame, reader ready");
        xfer_log.delete(); last_log.delete(); peak_avail = 0;
        sendFrame(0, 0, 0);
        drain(100);
        checkOutput("t1_beats", 64'(xfer_log.size()), 64'd16);
        if (xfer_log.size() == 16) begin
            checkOutput("t1_beat0", xfer_log[0], 64'h0003_0002_0001_0000);
            checkOutput("t1_beat15", xfer_log[15], 64'h003F_003E_003D_003C);
            checkOutput("t1_last15", 64'(last_log[15]), 64'd1);
            checkOutput("t1_last0", 64'(last_log[0]), 64'd0);
        end
        checkOutput("t1_avail_peak", 64'(peak_avail), 64'd1);

        // reader stalled: two frames buffered, third dropped
        $display("[TB] overflow with reader stalled");
        ready_mode = 0;
        xfer_log.delete(); last_log.delete();
        sendFrame(1, 0, 2);
        sendFrame(1, 1, 2);
        sendFrame(1, 2, 2);
        checkOutput("t2_avail", 64'(frames_avail), 64'd2);
        checkOutput("t2_overflow", 64'(overflow), 64'd1);
        checkOutput("t2_drop", 64'(drop_count), 64'd1);
        ready_mode = 1;
        drain(200);
        checkOutput("t2_beats", 64'(xfer_log.size()), 64'd32);
        if (xfer_log.size() == 32) begin
            checkOutput("t2_f0b0", xfer_log[0], beatVal(1, 0, 0));
            checkOutput("t2_f1b15", xfer_log[31], beatVal(1, 1, 15));
        end

        // abort at beat 5 restarts the capture
        $display("[TB] abort mid-capture");
        applyStimulus(1'b0, 64'd0, 1'b1);
        xfer_log.delete(); last_log.delete();
        applyStimulus(1'b1, 64'd0, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, beatVal(1, 9, k), 1'b0);
        sendFrame(1, 10, 2);
        checkOutput("t3_drop", 64'(drop_count), 64'd1);
        drain(100);
        checkOutput("t3_beats", 64'(xfer_log.size()), 64'd16);
        if (xfer_log.size() == 16) checkOutput("t3_b0", xfer_log[0], beatVal(1, 10, 0));

        // random back-pressure and random gaps
        $display("[TB] random back-pressure");
        applyStimulus(1'b0, 64'd0, 1'b1);
        ready_mode = 2;
        xfer_log.delete(); last_log.delete(); pushed = 0;
        for (int f = 0; f < 8; f++) sendFrame(2, f, $urandom_range(0, 20));
        capture_en = 0;
        applyStimulus(1'b1, 64'd0, 1'b0);
        applyStimulus(1'b0, 64'd0, 1'b0);
        capture_en = 1;
        applyStimulus(1'b1, 64'd0, 1'b0);
        for (int k = 0; k < FB; k++) begin
            if (k == 8) capture_en = 0;
            applyStimulus(1'b0, beatVal(2, 0, k), 1'b0);
        end
        capture_en = 1;
        drain(3000);
        checkOutput("t4_beats", 64'(xfer_log.size()), 64'(16 * pushed));

        // reset mid-capture, then drop and clear in the same cycle
        $display("[TB] reset mid-capture, clear vs drop");
        applyStimulus(1'b0, 64'd0, 1'b1);
        ready_mode = 0;
        sendFrame(1, 20, 1);
        applyStimulus(1'b1, 64'd0, 1'b0);
        for (int k = 0; k < 7; k++) applyStimulus(1'b0, beatVal(1, 21, k), 1'b0);
        doReset();
        checkOutput("t5_valid_after", 64'(rd_valid), 64'd0);
        checkOutput("t5_avail_after", 64'(frames_avail), 64'd0);
        sendFrame(1, 22, 1);
        sendFrame(1, 23, 1);
        applyStimulus(1'b1, 64'd0, 1'b1);
        checkOutput("t5_clear_drop", 64'(drop_count), 64'd0);
        checkOutput("t5_clear_ovf", 64'(overflow), 64'd0);
        applyStimulus(1'b1, 64'd0, 1'b0);
        checkOutput("t5_drop_after", 64'(drop_count), 64'd1);
        checkOutput("t5_ovf_after", 64'(overflow), 64'd1);
        ready_mode = 1;
        drain(200);

        // checksum pattern
        $display("[TB] checksum pattern");
        sendFrame(3, 0, 0);
        for (int n = 0; n < 10 && !rd_valid; n++) applyStimulus(1'b0, 64'd0, 1'b0);
        checkOutput("t6_valid", 64'(rd_valid), 64'd1);
`ifdef DFT_CAPTURE_CHECKSUM_EN
        checkOutput("t6_csum", frame_csum, 64'h1111_2222_3333_4444);
`else
        checkOutput("t6_csum", frame_csum, 64'd0);
`endif
        drain(100);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
